// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the cpu core:
// forwarding encodings, special registers and per-stage tracking info.
package cpu_pkg;

    localparam int REG_AW = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              is_load;
        logic [REG_AW-1:0] rn;
        logic              use_rn;
        logic [REG_AW-1:0] rm;
        logic              use_rm;
    } stage_info_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX source register.
// Compares against the MEM and WB writers; the younger MEM value wins.
module fwd_select
    import cpu_pkg::*;
#(
    parameter int RA_W = REG_AW
) (
    input  logic            src_use,
    input  logic [RA_W-1:0] src,
    input  logic            mem_valid,
    input  logic            mem_wr,
    input  logic            mem_is_load,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            wb_valid,
    input  logic            wb_wr,
    input  logic [RA_W-1:0] wb_rd,
    output logic [1:0]      sel
);

    always_comb begin
        sel = FWD_RF;
        // The PC is read through its own path, never from a stage result.
        if (src_use && (src != RA_W'(REG_PC))) begin
            if (mem_valid && mem_wr && !mem_is_load && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_valid && wb_wr && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: stalls, flushes, enables and ALU forwarding.
// Tracks EX/MEM/WB destinations to resolve load-use and branch hazards.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int RA_W           = REG_AW,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rn,
    input  logic [RA_W-1:0]  id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_wr_rd,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             ext_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_en,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] HOLD_INIT = 2'(LOAD_USE_STALL - 1);

    stage_info_t      id_info;
    stage_info_t      ex_q, ex_d;
    stage_info_t      mem_q, mem_d;
    stage_info_t      wb_q, wb_d;
    logic [1:0]       hold_q, hold_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             branch;
    logic             load_use;
    logic             bubble;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;
    logic             wb_unused;

    always_comb begin
        id_info         = '0;
        id_info.valid   = id_valid;
        id_info.rd      = id_rd;
        id_info.wr      = id_wr_rd;
        id_info.is_load = id_is_load;
        id_info.rn      = id_rn;
        id_info.use_rn  = id_use_rn;
        id_info.rm      = id_rm;
        id_info.use_rm  = id_use_rm;
    end

    assign branch   = ex_q.valid && ex_branch_taken;
    assign load_use = id_valid && ex_q.valid && ex_q.wr && ex_q.is_load &&
                      ((id_use_rn && (id_rn == ex_q.rd)) ||
                       (id_use_rm && (id_rm == ex_q.rd)));
    // A running hold count keeps ID frozen even though EX is now a bubble.
    assign bubble   = load_use || (hold_q != 2'd0);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_en     = 1'b1;
        hold_d      = hold_q;
        stall_cnt_d = stall_cnt_q;
        if (nreset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pipe_en     = 1'b0;
            hold_d      = 2'd0;
            stall_cnt_d = '0;
        end else if (ext_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
        end else if (branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            hold_d     = 2'd0;
        end else if (bubble) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            hold_d     = (hold_q != 2'd0) ? hold_q - 2'd1 : HOLD_INIT;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (nreset) begin
            ex_d  = '0;
            mem_d = '0;
            wb_d  = '0;
        end else if (pipe_en) begin
            ex_d  = idex_flush ? '0 : id_info;
            mem_d = ex_q;
            wb_d  = mem_q;
        end
    end

    always_ff @(posedge clk) begin
        ex_q        <= ex_d;
        mem_q       <= mem_d;
        wb_q        <= wb_d;
        hold_q      <= hold_d;
        stall_cnt_q <= stall_cnt_d;
    end

    fwd_select #(.RA_W(RA_W)) u_fwd_a (
        .src_use     (ex_q.use_rn),
        .src         (ex_q.rn),
        .mem_valid   (mem_q.valid),
        .mem_wr      (mem_q.wr),
        .mem_is_load (mem_q.is_load),
        .mem_rd      (mem_q.rd),
        .wb_valid    (wb_q.valid),
        .wb_wr       (wb_q.wr),
        .wb_rd       (wb_q.rd),
        .sel         (fwd_a_raw)
    );

    fwd_select #(.RA_W(RA_W)) u_fwd_b (
        .src_use     (ex_q.use_rm),
        .src         (ex_q.rm),
        .mem_valid   (mem_q.valid),
        .mem_wr      (mem_q.wr),
        .mem_is_load (mem_q.is_load),
        .mem_rd      (mem_q.rd),
        .wb_valid    (wb_q.valid),
        .wb_wr       (wb_q.wr),
        .wb_rd       (wb_q.rd),
        .sel         (fwd_b_raw)
    );

    assign fwd_a_sel = nreset ? FWD_RF : fwd_a_raw;
    assign fwd_b_sel = nreset ? FWD_RF : fwd_b_raw;
    assign stall_cnt = stall_cnt_q;

    // WB is the last tracked stage; its source fields retire unread.
    assign wb_unused = ^{wb_q.is_load, wb_q.rn, wb_q.use_rn,
                         wb_q.rm, wb_q.use_rm};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed ID-stage vectors with
// hand-computed control/forwarding outputs, checked by a negedge monitor.
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] NRM = 5'b11001;
    localparam logic [4:0] RST = 5'b00110;
    localparam logic [4:0] BUB = 5'b00011;
    localparam logic [4:0] BRF = 5'b11111;
    localparam logic [4:0] FRZ = 5'b00000;

    logic       clk;
    logic       nreset;
    logic       id_valid;
    logic [3:0] id_rn;
    logic [3:0] id_rm;
    logic       id_use_rn;
    logic       id_use_rm;
    logic [3:0] id_rd;
    logic       id_wr_rd;
    logic       id_is_load;
    logic       br;
    logic       ext;

    logic        pc_en1, ifid_en1, ifid_flush1, idex_flush1, pipe_en1;
    logic [1:0]  fa1, fb1;
    logic [15:0] cnt1;
    logic        pc_en2, ifid_en2, ifid_flush2, idex_flush2, pipe_en2;
    logic [1:0]  fa2, fb2;
    logic [1:0]  cnt2;

    typedef struct {
        string       nm;
        logic        tgt;
        logic [4:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic        tgt;
    logic [4:0]  act_ctl;
    logic [1:0]  act_fa;
    logic [1:0]  act_fb;
    logic [15:0] act_cnt;
    int          n_vec;
    int          n_err;

    pipe_hazard_ctrl #(.RA_W(4), .LOAD_USE_STALL(1), .CNT_W(16)) dut1 (
        .clk(clk), .nreset(nreset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .id_rd(id_rd), .id_wr_rd(id_wr_rd), .id_is_load(id_is_load),
        .ex_branch_taken(br), .ext_stall(ext),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
        .idex_flush(idex_flush1), .pipe_en(pipe_en1),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cnt(cnt1)
    );

    pipe_hazard_ctrl #(.RA_W(4), .LOAD_USE_STALL(2), .CNT_W(2)) dut2 (
        .clk(clk), .nreset(nreset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .id_rd(id_rd), .id_wr_rd(id_wr_rd), .id_is_load(id_is_load),
        .ex_branch_taken(br), .ext_stall(ext),
        .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2),
        .idex_flush(idex_flush2), .pipe_en(pipe_en2),
        .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.tgt) begin
                act_ctl = {pc_en2, ifid_en2, ifid_flush2, idex_flush2, pipe_en2};
                act_fa  = fa2;
                act_fb  = fb2;
                act_cnt = {14'd0, cnt2};
            end else begin
                act_ctl = {pc_en1, ifid_en1, ifid_flush1, idex_flush1, pipe_en1};
                act_fa  = fa1;
                act_fb  = fb1;
                act_cnt = cnt1;
            end
            n_vec++;
            if ({act_ctl, act_fa, act_fb, act_cnt} !== {e.ctl, e.fa, e.fb, e.cnt}) begin
                n_err++;
                $display("FAIL %s: got ctl=%b fa=%0d fb=%0d cnt=%h, want ctl=%b fa=%0d fb=%0d cnt=%h",
                         e.nm, act_ctl, act_fa, act_fb, act_cnt, e.ctl, e.fa, e.fb, e.cnt);
            end
        end
    end

    task automatic set_id(input logic v, input logic [3:0] d, input logic [3:0] n,
                          input logic un, input logic [3:0] m, input logic um,
                          input logic w, input logic l);
        id_valid   = v;
        id_rd      = d;
        id_rn      = n;
        id_use_rn  = un;
        id_rm      = m;
        id_use_rm  = um;
        id_wr_rd   = w;
        id_is_load = l;
    endtask

    task automatic add(input logic [3:0] d, input logic [3:0] n, input logic [3:0] m);
        set_id(1'b1, d, n, 1'b1, m, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic ldr(input logic [3:0] d, input logic [3:0] n);
        set_id(1'b1, d, n, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic nop();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input string nm, input logic [4:0] ctl,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [15:0] cnt);
        sb.push_back('{nm, tgt, ctl, fa, fb, cnt});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        tgt = 1'b0;
        nreset = 1'b1;
        ext = 1'b0;
        br = 1'b0;
        nop();
        @(posedge clk);
        #1;
        step("rst_a", RST, 0, 0, 0);
        step("rst_b", RST, 0, 0, 0);
        nreset = 1'b0;
        step("rel", NRM, 0, 0, 0);
        // back-to-back dependent ADDs, then with a NOP gap
        add(1, 2, 3); step("s2_1", NRM, 0, 0, 0);
        add(4, 1, 5); step("s2_2", NRM, 0, 0, 0);
        nop();        step("fwd_mem_a", NRM, 1, 0, 0);
        add(1, 2, 3); step("s2_4", NRM, 0, 0, 0);
        nop();        step("s2_5", NRM, 0, 0, 0);
        add(4, 1, 5); step("s2_6", NRM, 0, 0, 0);
        nop();        step("fwd_wb_a", NRM, 2, 0, 0);
        add(6, 2, 3); step("p_1", NRM, 0, 0, 0);
        add(6, 4, 5); step("p_2", NRM, 0, 0, 0);
        add(7, 8, 6); step("p_3", NRM, 0, 0, 0);
        nop();        step("fwd_mem_prio", NRM, 0, 1, 0);
        add(9, 7, 7); step("p_5", NRM, 0, 0, 0);
        nop();        step("fwd_wb_ab", NRM, 2, 2, 0);
        // load-use, single bubble
        ldr(1, 2);    step("lu_0", NRM, 0, 0, 0);
        add(3, 1, 4); step("lu_bubble", BUB, 0, 0, 0);
                      step("lu_release", NRM, 0, 0, 1);
        nop();        step("lu_fwd_wb", NRM, 2, 0, 1);
        // external stall across a dependent pair
        add(1, 2, 3); step("s5_a", NRM, 0, 0, 1);
        add(4, 1, 5); step("s5_b", NRM, 0, 2, 1);
        nop(); ext = 1'b1;
                      step("ext_0", FRZ, 1, 0, 1);
        br = 1'b1;    step("ext_br", FRZ, 1, 0, 1);
        br = 1'b0;    step("ext_2", FRZ, 1, 0, 1);
        ext = 1'b0;   step("ext_resume", NRM, 1, 0, 1);
        ldr(1, 2);    step("el_0", NRM, 0, 0, 1);
        add(3, 1, 4); ext = 1'b1;
                      step("ext_over_lu", FRZ, 0, 0, 1);
        ext = 1'b0;   step("el_bub", BUB, 0, 0, 1);
                      step("el_rel", NRM, 0, 0, 2);
        nop();        step("el_fwd", NRM, 2, 0, 2);
        // hazard through rm, and unused operands
        ldr(5, 2);    step("rm_0", NRM, 0, 0, 2);
        add(6, 7, 5); step("lu_rm", BUB, 0, 0, 2);
                      step("lu_rm_rel", NRM, 0, 0, 3);
        nop();        step("lu_rm_fwd", NRM, 0, 2, 3);
        ldr(5, 2);    step("un_0", NRM, 0, 0, 3);
        set_id(1, 8, 1, 1, 5, 0, 1, 0);
                      step("lu_unused", NRM, 0, 0, 3);
        nop();        step("un_2", NRM, 0, 0, 3);
        set_id(1, 9, 8, 0, 8, 1, 1, 0);
                      step("un_3", NRM, 0, 0, 3);
        nop();        step("unused_rn", NRM, 0, 2, 3);
        // taken branches
        add(1, 2, 3); step("b_0", NRM, 0, 0, 3);
        add(4, 5, 6); br = 1'b1;
                      step("branch", BRF, 0, 0, 3);
        nop(); br = 1'b0;
                      step("b_2", NRM, 0, 0, 3);
        br = 1'b1;    step("br_ex_inv", NRM, 0, 0, 3);
        br = 1'b0;
        ldr(15, 2);   step("bl_0", NRM, 0, 0, 3);
        add(3, 15, 4); br = 1'b1;
                      step("br_over_lu", BRF, 0, 0, 3);
        nop(); br = 1'b0;
                      step("br_no_stall", NRM, 0, 0, 3);
        // R15 is never forwarded; LR writer forwards normally
        add(15, 2, 3);  step("r_0", NRM, 0, 0, 3);
        add(7, 15, 15); step("r_1", NRM, 0, 0, 3);
        add(8, 15, 15); step("r15_mem", NRM, 0, 0, 3);
        nop();          step("r15_wb", NRM, 0, 0, 3);
        set_id(1, 14, 0, 0, 0, 0, 1, 0);
                        step("lr_0", NRM, 0, 0, 3);
        add(5, 14, 1);  step("lr_1", NRM, 0, 0, 3);
        nop();          step("bl_lr", NRM, 1, 0, 3);

        // second instance: two bubbles per hazard, 2-bit counter
        tgt = 1'b1;
        nreset = 1'b1;
        nop();
        @(posedge clk);
        #1;
        step("d2_rst", RST, 0, 0, 0);
        nreset = 1'b0;
        step("d2_rel", NRM, 0, 0, 0);
        ldr(1, 2);    step("lu2_0", NRM, 0, 0, 0);
        add(3, 1, 4); step("lu2_a", BUB, 0, 0, 0);
                      step("lu2_b", BUB, 0, 0, 1);
                      step("lu2_c", NRM, 0, 0, 2);
        nop();        step("lu2_rf", NRM, 0, 0, 2);
        ldr(1, 2);    step("sat_0", NRM, 0, 0, 2);
        add(3, 1, 4); step("sat_1", BUB, 0, 0, 2);
                      step("sat_2", BUB, 0, 0, 3);
                      step("sat", NRM, 0, 0, 3);
        nop();        step("sat_4", NRM, 0, 0, 3);
        ldr(15, 2);   step("d2_b0", NRM, 0, 0, 3);
        add(3, 15, 4); br = 1'b1;
                      step("d2_br", BRF, 0, 0, 3);
        nop(); br = 1'b0;
                      step("d2_br_cancel", NRM, 0, 0, 3);
        ldr(1, 2);    step("mr_0", NRM, 0, 0, 3);
        add(3, 1, 4); step("lu_pre_rst", BUB, 0, 0, 3);
        nreset = 1'b1;
                      step("rst_mid_a", RST, 0, 0, 3);
                      step("rst_mid_b", RST, 0, 0, 0);
        nreset = 1'b0;
                      step("rst_no_stale", NRM, 0, 0, 0);

        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
